fp32_uart_tx: RTL and testbench

FP32_UART_TX -- requirements
Module: fp32_uart_tx

---
 rtl/fp32_uart_tx.sv | 147 ++++++++++++++
 tb/tb_fp32_uart_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fp32_uart_tx.sv
`timescale 1ns/1ps
// Serialises one NUM_BYTES word onto a UART line, byte 0 first, LSB first, 8N1.
// Build option FP32_UART_TX_PARITY_EN adds an even-parity bit per byte (8E1).
module fp32_uart_tx #(
    parameter int CLKS_PER_BIT = 443,
    parameter int NUM_BYTES    = 4
) (
    input  logic                   CLK_I,
    input  logic                   RSTL_I,
    input  logic                   TX_VALID_I,
    input  logic [8*NUM_BYTES-1:0] TX_DATA_I,
    output logic                   TX_READY_O,
    output logic                   UART_TX_O,
    output logic                   TX_BUSY_O,
    output logic                   TX_DONE_O
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int WW = 8 * NUM_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef FP32_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [BW-1:0]   r_byte, w_byte_nxt;
    logic [WW-1:0]   r_shift, w_shift_nxt;
    logic            w_bit_end, w_last_byte;
    logic            w_tx_nxt, w_ready_nxt, w_busy_nxt, w_done_nxt;
`ifdef FP32_UART_TX_PARITY_EN
    logic            r_par, w_par_nxt;
`endif

    assign w_bit_end   = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_last_byte = (r_byte == BW'(NUM_BYTES - 1));

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (TX_VALID_I) w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
`ifdef FP32_UART_TX_PARITY_EN
            S_DATA:   if (w_bit_end && r_bit == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`else
            S_DATA:   if (w_bit_end && r_bit == 3'd7) w_state_nxt = S_STOP;
`endif
            S_STOP:   if (w_bit_end) w_state_nxt = w_last_byte ? S_DONE : S_START;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: the word shifts right one bit per data bit, so byte k follows byte k-1 naturally.
    always_comb begin
        w_cnt_nxt   = '0;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_shift_nxt = r_shift;
`ifdef FP32_UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (TX_VALID_I) begin
                    w_shift_nxt = TX_DATA_I;
                    w_byte_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            end
            S_DONE: w_cnt_nxt = '0;
            default: begin
                w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
`ifdef FP32_UART_TX_PARITY_EN
                if (r_state == S_START) w_par_nxt = 1'b0;
                if (r_state == S_DATA && w_bit_end) w_par_nxt = r_par ^ r_shift[0];
`endif
                if (r_state == S_DATA && w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    w_bit_nxt   = r_bit + 1'b1;
                end
                if (r_state == S_STOP && w_bit_end) w_byte_nxt = r_byte + 1'b1;
            end
        endcase
    end

    // Outputs are decoded from next-state values and then registered, so the line has no input-to-pin path.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef FP32_UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = w_par_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = !w_ready_nxt;
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_shift    <= '0;
`ifdef FP32_UART_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
            UART_TX_O  <= 1'b1;
            TX_READY_O <= 1'b1;
            TX_BUSY_O  <= 1'b0;
            TX_DONE_O  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_byte     <= w_byte_nxt;
            r_shift    <= w_shift_nxt;
`ifdef FP32_UART_TX_PARITY_EN
            r_par      <= w_par_nxt;
`endif
            UART_TX_O  <= w_tx_nxt;
            TX_READY_O <= w_ready_nxt;
            TX_BUSY_O  <= w_busy_nxt;
            TX_DONE_O  <= w_done_nxt;
        end
    end
endmodule

// File: tb/tb_fp32_uart_tx.sv
`timescale 1ns/1ps
// Bench for fp32_uart_tx: acceptances push words into a queue; a line monitor
// checks every bit level/width against the word and pops it at frame end.
module tb_fp32_uart_tx;
    localparam int CPB = 13;
    localparam int NB  = 4;
`ifdef FP32_UART_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int L      = NB * BITS * CPB;
    localparam int BUDGET = 2 * L + 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [31:0] dat = '0;
    logic        rdy, txl, busy, done;

    fp32_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
        .CLK_I      (clk),
        .RSTL_I     (rst_n),
        .TX_VALID_I (vld),
        .TX_DATA_I  (dat),
        .TX_READY_O (rdy),
        .UART_TX_O  (txl),
        .TX_BUSY_O  (busy),
        .TX_DONE_O  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    int          next_rdy_cyc = 0;
    int          done_cyc = -1;
    int          n_acc = 0;
    logic [31:0] exp_q[$];

    bit          mon_act = 0;
    int          t0 = 0;
    int          rel, g, ph;
    logic [31:0] rx_word;
    logic [31:0] popped;
    logic        exp_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line level for global bit g of a frame carrying word w.
    function automatic logic exp_bit(input logic [31:0] w, input int gb);
        int          k = gb / BITS;
        int          pos = gb % BITS;
        logic [31:0] sh = w >> (8 * k);
        logic [7:0]  b = sh[7:0];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (BITS == 11 && pos == 9) return ^b;
        return 1'b1;
    endfunction

    // Reference model + scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_line", {31'b0, txl}, 32'd1);
            chk("rst_ready", {31'b0, rdy}, 32'd1);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_done", {31'b0, done}, 32'd0);
            next_rdy_cyc = 0;
            done_cyc = -1;
            exp_q.delete();
            mon_act = 0;
        end else begin
            exp_rdy = (cyc >= next_rdy_cyc);
            chk("ready", {31'b0, rdy}, {31'b0, exp_rdy});
            chk("busy", {31'b0, busy}, {31'b0, !exp_rdy});
            chk("done", {31'b0, done}, {31'b0, cyc == done_cyc});
            if (vld && exp_rdy) begin
                exp_q.push_back(dat);
                done_cyc = cyc + 1 + L;
                next_rdy_cyc = cyc + 1 + L + 1;
                n_acc++;
            end

            if (!mon_act && txl == 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_start: line low with no word pending (cycle %0d)", cyc);
                end else begin
                    mon_act = 1;
                    t0 = cyc;
                    rx_word = '0;
                end
            end
            if (mon_act) begin
                rel = cyc - t0;
                g = rel / CPB;
                ph = rel % CPB;
                if (ph == 0)
                    chk("bit_lead", {31'b0, txl}, {31'b0, exp_bit(exp_q[0], g)});
                if (ph == CPB - 1)
                    chk("bit_tail", {31'b0, txl}, {31'b0, exp_bit(exp_q[0], g)});
                if (ph == CPB / 2 && (g % BITS) >= 1 && (g % BITS) <= 8)
                    rx_word[8 * (g / BITS) + (g % BITS) - 1] = txl;
                if (g == NB * BITS - 1 && ph == CPB - 1) begin
                    popped = exp_q.pop_front();
                    chk("word", rx_word, popped);
                    mon_act = 0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] w);
        int a0 = n_acc;
        vld = 1'b1;
        dat = w;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            #1;
            if (n_acc != a0) break;
        end
        if (n_acc == a0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: word %h not accepted, expected acceptance", w);
        end
        vld = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            #1;
            if (cyc >= next_rdy_cyc && exp_q.size() == 0 && !mon_act) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: pending=%0d, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'h3F80_0000);
        wait_idle();
        send(32'hC049_0FDB);
        wait_idle();

        // Valid held high with data changing every cycle: only ready-cycle samples go out.
        vld = 1'b1;
        for (int i = 0; i < 3 * (L + 1) + 7; i++) begin
            dat = $urandom;
            @(posedge clk);
            #1;
        end
        vld = 1'b0;
        wait_idle();

        // Reset mid-frame, then send immediately on release.
        send(32'hAABB_CCDD);
        repeat (150) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'h1234_5678);
        wait_idle();

        send(32'h0000_00FF);
        wait_idle();
        send(32'h0000_0001);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            send($urandom);
        end
        wait_idle();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
